atm_session_ctrl: RTL and testbench

Session/authentication controller that sequences the ATM account datapath. It decodes BTN1/BTN2/BTN3 presses and SW, and owns the password register, the wrong-attempt counter and the lockout timer. It issues single-cycle deposit/withdraw commands to the balance register and exports a state code for LED/7-segment display logic. It sits between the board inputs and the balance/display datapath inside atm_code.

---
 rtl/atm_session_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_atm_session_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/atm_session_ctrl.sv
// ATM session controller: button edge detection, PIN/password handling,
// lockout timing and single-cycle deposit/withdraw commands to the balance datapath.
module atm_session_ctrl #(
  parameter int          LOCK_LONG  = 100,
  parameter int          LOCK_SHORT = 50,
  parameter logic [3:0]  INIT_PWD   = 4'b0000,
  parameter int          TW         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       BTN3,
  input  logic       BTN2,
  input  logic       BTN1,
  input  logic [3:0] SW,
  input  logic [7:0] bal,
  output logic       dep_en,
  output logic       wdr_en,
  output logic [3:0] amount,
  output logic [2:0] state,
  output logic       locked,
  output logic [1:0] attempts,
  output logic       pin_err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PIN     = 3'd1,
    S_MENU    = 3'd2,
    S_MONEY   = 3'd3,
    S_PWD_OLD = 3'd4,
    S_PWD_NEW = 3'd5,
    S_LOCK    = 3'd6
  } state_t;

  state_t        state_q, state_d, ret_q, ret_d;
  logic [3:0]    pwd_q, pwd_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    attempts_q, attempts_d;
  logic [2:0]    btn_prev_q;
  logic          dep_en_q, dep_en_d, wdr_en_q, wdr_en_d, pin_err_q, pin_err_d;
  logic          locked_q, locked_d;
  logic [3:0]    amount_q, amount_d;

  logic [2:0] btn, press;
  logic       p1, p2, p3, bad_entry;
  logic [8:0] dep_sum;

  assign btn     = {BTN3, BTN2, BTN1};
  assign press   = btn & ~btn_prev_q;
  // Single winner per cycle: BTN1 beats BTN3 beats BTN2.
  assign p1      = press[0];
  assign p3      = press[2] & ~press[0];
  assign p2      = press[1] & ~press[0] & ~press[2];
  assign dep_sum = {1'b0, bal} + {5'b0, SW};

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    pwd_d      = pwd_q;
    timer_d    = timer_q;
    attempts_d = attempts_q;
    dep_en_d   = 1'b0;
    wdr_en_d   = 1'b0;
    pin_err_d  = 1'b0;
    amount_d   = amount_q;
    bad_entry  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (p3) begin
          state_d    = S_PIN;
          attempts_d = 2'd0;
        end
      end
      S_PIN: begin
        if (p1) state_d = S_IDLE;
        else if (p3) begin
          if (SW == pwd_q) begin
            state_d    = S_MENU;
            attempts_d = 2'd0;
          end else bad_entry = 1'b1;
        end
      end
      S_MENU: begin
        if (p1) state_d = S_IDLE;
        else if (p3) state_d = S_MONEY;
        else if (p2) begin
          state_d    = S_PWD_OLD;
          attempts_d = 2'd0;
        end
      end
      S_MONEY: begin
        if (p1) state_d = S_MENU;
        else if (p3) begin
          if (dep_sum <= 9'd255) begin
            dep_en_d = 1'b1;
            amount_d = SW;
          end
        end else if (p2) begin
          if ({4'b0, SW} <= bal) begin
            wdr_en_d = 1'b1;
            amount_d = SW;
          end else begin
            state_d = S_LOCK;
            timer_d = TW'(LOCK_SHORT - 1);
            ret_d   = S_MONEY;
          end
        end
      end
      S_PWD_OLD: begin
        if (p1) state_d = S_MENU;
        else if (p3) begin
          if (SW == pwd_q) begin
            state_d    = S_PWD_NEW;
            attempts_d = 2'd0;
          end else bad_entry = 1'b1;
        end
      end
      S_PWD_NEW: begin
        if (p1) state_d = S_MENU;
        else if (p3) begin
          pwd_d   = SW;
          state_d = S_MENU;
        end
      end
      S_LOCK: begin
        if (timer_q == '0) state_d = ret_q;
        else timer_d = timer_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Wrong entry in PIN or PWD_OLD; the third one logs the session out via a long lock.
    if (bad_entry) begin
      pin_err_d = 1'b1;
      if (attempts_q == 2'd2) begin
        state_d    = S_LOCK;
        timer_d    = TW'(LOCK_LONG - 1);
        ret_d      = S_IDLE;
        attempts_d = 2'd0;
      end else begin
        attempts_d = attempts_q + 2'd1;
      end
    end

    locked_d = (state_d == S_LOCK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ret_q      <= S_IDLE;
      pwd_q      <= INIT_PWD;
      timer_q    <= '0;
      attempts_q <= 2'd0;
      btn_prev_q <= 3'b000;
      dep_en_q   <= 1'b0;
      wdr_en_q   <= 1'b0;
      pin_err_q  <= 1'b0;
      locked_q   <= 1'b0;
      amount_q   <= 4'd0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      pwd_q      <= pwd_d;
      timer_q    <= timer_d;
      attempts_q <= attempts_d;
      btn_prev_q <= btn;
      dep_en_q   <= dep_en_d;
      wdr_en_q   <= wdr_en_d;
      pin_err_q  <= pin_err_d;
      locked_q   <= locked_d;
      amount_q   <= amount_d;
    end
  end

  assign state    = state_q;
  assign dep_en   = dep_en_q;
  assign wdr_en   = wdr_en_q;
  assign amount   = amount_q;
  assign locked   = locked_q;
  assign attempts = attempts_q;
  assign pin_err  = pin_err_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Directed-vector bench for atm_session_ctrl: each press is applied for one edge,
// the post-edge outputs are snapshotted and compared against hand-computed values.
module tb_atm_session_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       BTN3, BTN2, BTN1;
  logic [3:0] SW;
  logic [7:0] bal;
  logic       dep_en, wdr_en, locked, pin_err;
  logic [3:0] amount;
  logic [2:0] state;
  logic [1:0] attempts;

  int vectors = 0;
  int miscompares = 0;

  // Snapshot of outputs right after the edge that detected a press.
  logic [2:0] s_state;
  logic [1:0] s_att;
  logic [3:0] s_amt;
  logic       s_dep, s_wdr, s_pin, s_locked;

  atm_session_ctrl dut (
    .clk(clk), .rst(rst), .BTN3(BTN3), .BTN2(BTN2), .BTN1(BTN1), .SW(SW), .bal(bal),
    .dep_en(dep_en), .wdr_en(wdr_en), .amount(amount), .state(state),
    .locked(locked), .attempts(attempts), .pin_err(pin_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  // b = {BTN3, BTN2, BTN1}; held for exactly one edge, then released for one edge.
  task automatic press(input logic [2:0] b);
    {BTN3, BTN2, BTN1} = b;
    tick();
    s_state = state; s_att = attempts; s_amt = amount;
    s_dep = dep_en; s_wdr = wdr_en; s_pin = pin_err; s_locked = locked;
    {BTN3, BTN2, BTN1} = 3'b000;
    tick();
  endtask

  // Counts locked cycles starting from the snapshot; BTN3 toggles meanwhile and must be ignored.
  task automatic lock_len(output int n);
    int guard;
    n = s_locked ? 1 : 0;
    guard = 0;
    while (locked && guard < 400) begin
      n++;
      guard++;
      BTN3 = guard[2];
      tick();
    end
    BTN3 = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; BTN3 = 0; BTN2 = 0; BTN1 = 0; SW = 4'd0; bal = 8'd0;
    tick(); tick();
    chk("rst_state", 32'(state), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_outs", 32'({dep_en, wdr_en, pin_err, attempts, amount}), 0);
    rst = 1'b0;
    tick();

    // 1: login with INIT_PWD and deposit
    press(3'b100); chk("t1_pin", 32'(s_state), 1);
    SW = 4'd0; press(3'b100); chk("t1_menu", 32'(s_state), 2); chk("t1_att", 32'(s_att), 0);
    press(3'b100); chk("t1_money", 32'(s_state), 3);
    SW = 4'd5; bal = 8'd0; press(3'b100);
    chk("t1_dep", 32'(s_dep), 1); chk("t1_amt", 32'(s_amt), 5); chk("t1_nowdr", 32'(s_wdr), 0);
    chk("t1_dep_off", 32'(dep_en), 0); chk("t1_amt_hold", 32'(amount), 5);

    // 2: password change to 1001
    press(3'b001); chk("t2_menu", 32'(s_state), 2);
    press(3'b010); chk("t2_old", 32'(s_state), 4);
    SW = 4'd0; press(3'b100); chk("t2_new", 32'(s_state), 5);
    SW = 4'd9; press(3'b100); chk("t2_menu2", 32'(s_state), 2);
    press(3'b001); chk("t2_idle", 32'(s_state), 0);
    press(3'b100); SW = 4'd9; press(3'b100); chk("t2_newpwd", 32'(s_state), 2);
    press(3'b001); chk("t2_logout", 32'(s_state), 0);

    // 3: three wrong PINs -> long lock -> IDLE
    press(3'b100); chk("t3_pin", 32'(s_state), 1);
    SW = 4'd0; press(3'b100); chk("t3_err1", 32'(s_pin), 1); chk("t3_att1", 32'(s_att), 1);
    SW = 4'd4; press(3'b100); chk("t3_att2", 32'(s_att), 2);
    SW = 4'd2; press(3'b100); chk("t3_err3", 32'(s_pin), 1); chk("t3_att0", 32'(s_att), 0);
    chk("t3_lock", 32'(s_state), 6);
    lock_len(n); chk("t3_locklen", 32'(n), 100); chk("t3_ret", 32'(state), 0);

    // 4: withdraw ok, then insufficient -> short lock -> MONEY
    press(3'b100); SW = 4'd9; press(3'b100); press(3'b100); chk("t4_money", 32'(s_state), 3);
    bal = 8'd5; SW = 4'd4; press(3'b010);
    chk("t4_wdr", 32'(s_wdr), 1); chk("t4_amt", 32'(s_amt), 4); chk("t4_nodep", 32'(s_dep), 0);
    bal = 8'd1; SW = 4'd2; press(3'b010);
    chk("t4_nowdr", 32'(s_wdr), 0); chk("t4_lock", 32'(s_locked), 1);
    lock_len(n); chk("t4_locklen", 32'(n), 50); chk("t4_ret", 32'(state), 3);
    press(3'b001); chk("t4_menu", 32'(s_state), 2);

    // 5: three wrong old passwords -> long lock -> IDLE, password unchanged
    press(3'b010); chk("t5_old", 32'(s_state), 4);
    SW = 4'd4;  press(3'b100); chk("t5_att1", 32'(s_att), 1);
    SW = 4'd0;  press(3'b100); chk("t5_att2", 32'(s_att), 2);
    SW = 4'd14; press(3'b100); chk("t5_lock", 32'(s_state), 6);
    lock_len(n); chk("t5_locklen", 32'(n), 100); chk("t5_ret", 32'(state), 0);
    press(3'b100); SW = 4'd9; press(3'b100); chk("t5_oldpwd", 32'(s_state), 2);

    // 6: corner cases
    press(3'b100);
    bal = 8'd0; SW = 4'd3; press(3'b101);
    chk("t6_prio_state", 32'(s_state), 2); chk("t6_prio_nodep", 32'(s_dep), 0);
    press(3'b100);
    bal = 8'd252; SW = 4'd5; press(3'b100);
    chk("t6_ovf_nodep", 32'(s_dep), 0); chk("t6_ovf_state", 32'(s_state), 3);
    bal = 8'd250; press(3'b100); chk("t6_edge_dep", 32'(s_dep), 1);
    SW = 4'd0; press(3'b100); chk("t6_zero_dep", 32'(s_dep), 1); chk("t6_zero_amt", 32'(s_amt), 0);
    bal = 8'd0; SW = 4'd0; press(3'b010); chk("t6_zero_wdr", 32'(s_wdr), 1);
    press(3'b001); press(3'b001); chk("t6_idle", 32'(s_state), 0);
    press(3'b100);
    SW = 4'd1; press(3'b100); press(3'b100); press(3'b100);
    chk("t6_lock", 32'(locked), 1);
    tick(); tick(); tick();
    rst = 1'b1; tick();
    chk("t6_rst_state", 32'(state), 0); chk("t6_rst_locked", 32'(locked), 0);
    rst = 1'b0; tick();
    press(3'b100); SW = 4'd0; press(3'b100); chk("t6_initpwd", 32'(s_state), 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
